// File: rtl/turn_controller.sv
// Connect Four turn sequencer: validates moves against column fill levels,
// strobes the board once per accepted move, then settles and resolves win/draw/turn.
module turn_controller #(
  parameter int NUM_COLS      = 8,
  parameter int MAX_ROWS      = 6,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     move_req,
  input  logic [3:0]               move_col,
  input  logic [NUM_COLS-1:0][2:0] counters,
  input  logic                     win_detected,
  output logic [3:0]               board_column,
  output logic                     player,
  output logic                     busy,
  output logic                     move_rejected,
  output logic                     game_over,
  output logic                     winner,
  output logic                     draw,
  output logic [5:0]               move_count
);

  localparam logic [2:0] WAIT_MOVE = 3'd0;
  localparam logic [2:0] ISSUE     = 3'd1;
  localparam logic [2:0] SETTLE    = 3'd2;
  localparam logic [2:0] CHECK     = 3'd3;
  localparam logic [2:0] GAME_OVER = 3'd4;

  localparam logic [3:0] COLS_W      = 4'(NUM_COLS);
  localparam logic [2:0] ROWS_W      = 3'(MAX_ROWS);
  localparam logic [3:0] SETTLE_W    = 4'(SETTLE_CYCLES);
  localparam logic [5:0] TOTAL_MOVES = 6'(NUM_COLS * MAX_ROWS);

  logic [2:0] state_q, state_d;
  logic [3:0] col_q, col_d;
  logic [3:0] settle_q, settle_d;
  logic [3:0] board_column_q, board_column_d;
  logic       player_q, player_d;
  logic       busy_q, busy_d;
  logic       rejected_q, rejected_d;
  logic       game_over_q, game_over_d;
  logic       winner_q, winner_d;
  logic       draw_q, draw_d;
  logic [5:0] count_q, count_d;

  logic [2:0] sel_count;
  logic       col_in_range;
  logic       legal;

  // Column select by explicit match so an out-of-range request never indexes counters.
  always_comb begin
    sel_count = '0;
    for (int i = 0; i < NUM_COLS; i++) begin
      if (move_col == 4'(i + 1)) sel_count = counters[i];
    end
    col_in_range = (move_col != 4'd0) && (move_col <= COLS_W);
    legal        = col_in_range && (sel_count < ROWS_W);
  end

  always_comb begin
    state_d        = state_q;
    col_d          = col_q;
    settle_d       = settle_q;
    board_column_d = '0;
    player_d       = player_q;
    rejected_d     = 1'b0;
    game_over_d    = game_over_q;
    winner_d       = winner_q;
    draw_d         = draw_q;
    count_d        = count_q;

    case (state_q)
      WAIT_MOVE: begin
        if (move_req) begin
          if (legal) begin
            col_d          = move_col;
            board_column_d = move_col;
            state_d        = ISSUE;
          end else begin
            rejected_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        state_d  = SETTLE;
        settle_d = SETTLE_W;
        if (count_q != TOTAL_MOVES) count_d = count_q + 6'd1;
      end
      SETTLE: begin
        if (settle_q <= 4'd1) begin
          state_d = CHECK;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      CHECK: begin
        if (win_detected) begin
          game_over_d = 1'b1;
          winner_d    = player_q;
          state_d     = GAME_OVER;
        end else if (count_q == TOTAL_MOVES) begin
          game_over_d = 1'b1;
          draw_d      = 1'b1;
          state_d     = GAME_OVER;
        end else begin
          player_d = ~player_q;
          state_d  = WAIT_MOVE;
        end
      end
      GAME_OVER: begin
        state_d = GAME_OVER;
      end
      default: begin
        state_d = WAIT_MOVE;
      end
    endcase

    // Requests arriving outside WAIT_MOVE are dropped, never queued.
    if (move_req && (state_q != WAIT_MOVE)) rejected_d = 1'b1;

    busy_d = (state_d != WAIT_MOVE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= WAIT_MOVE;
      col_q          <= '0;
      settle_q       <= '0;
      board_column_q <= '0;
      player_q       <= 1'b0;
      busy_q         <= 1'b0;
      rejected_q     <= 1'b0;
      game_over_q    <= 1'b0;
      winner_q       <= 1'b0;
      draw_q         <= 1'b0;
      count_q        <= '0;
    end else begin
      state_q        <= state_d;
      col_q          <= col_d;
      settle_q       <= settle_d;
      board_column_q <= board_column_d;
      player_q       <= player_d;
      busy_q         <= busy_d;
      rejected_q     <= rejected_d;
      game_over_q    <= game_over_d;
      winner_q       <= winner_d;
      draw_q         <= draw_d;
      count_q        <= count_d;
    end
  end

  assign board_column  = board_column_q;
  assign player        = player_q;
  assign busy          = busy_q;
  assign move_rejected = rejected_q;
  assign game_over     = game_over_q;
  assign winner        = winner_q;
  assign draw          = draw_q;
  assign move_count    = count_q;

endmodule

// File: tb/tb_turn_controller.sv
// Directed bench for turn_controller: legal/illegal moves, busy rejection,
// win, full-board draw and asynchronous reset mid-strobe.
module tb_turn_controller;

  logic             clk = 1'b0;
  logic             reset;
  logic             move_req;
  logic [3:0]       move_col;
  logic [7:0][2:0]  counters;
  logic             win_detected;
  logic [3:0]       board_column;
  logic             player;
  logic             busy;
  logic             move_rejected;
  logic             game_over;
  logic             winner;
  logic             draw;
  logic [5:0]       move_count;

  int compared   = 0;
  int mismatched = 0;
  int strobe_cnt = 0;
  int rej_cnt    = 0;
  int fill [8];

  always #5 clk = ~clk;

  turn_controller #(
    .NUM_COLS(8),
    .MAX_ROWS(6),
    .SETTLE_CYCLES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .move_req(move_req),
    .move_col(move_col),
    .counters(counters),
    .win_detected(win_detected),
    .board_column(board_column),
    .player(player),
    .busy(busy),
    .move_rejected(move_rejected),
    .game_over(game_over),
    .winner(winner),
    .draw(draw),
    .move_count(move_count)
  );

  // Count strobes and reject pulses as seen just before each active edge.
  always @(posedge clk) begin
    if (board_column != 4'd0) strobe_cnt++;
    if (move_rejected) rej_cnt++;
  end

  task automatic chk(input string tag, input int obs, input int exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive a one-cycle request; returns at the negedge of the cycle after the sampling edge.
  task automatic issue(input logic [3:0] col);
    move_col = col;
    move_req = 1'b1;
    @(negedge clk);
    move_req = 1'b0;
    move_col = 4'd0;
  endtask

  task automatic play(input logic [3:0] col);
    int idx;
    idx = int'(col) - 1;
    issue(col);
    chk("draw_game strobe", int'(board_column), int'(col));
    fill[idx]++;
    counters[idx] = 3'(fill[idx]);
    tick(4);
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, " board_column"}, int'(board_column), 0);
    chk({tag, " player"}, int'(player), 0);
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " move_rejected"}, int'(move_rejected), 0);
    chk({tag, " game_over"}, int'(game_over), 0);
    chk({tag, " winner"}, int'(winner), 0);
    chk({tag, " draw"}, int'(draw), 0);
    chk({tag, " move_count"}, int'(move_count), 0);
  endtask

  initial begin
    int s0;
    int r0;
    logic [3:0] bad_cols [4];
    bad_cols[0] = 4'd5;
    bad_cols[1] = 4'd0;
    bad_cols[2] = 4'd9;
    bad_cols[3] = 4'd15;

    reset        = 1'b1;
    move_req     = 1'b0;
    move_col     = 4'd0;
    counters     = '0;
    win_detected = 1'b0;
    for (int i = 0; i < 8; i++) fill[i] = 0;

    // Reset state
    tick(2);
    chk_idle_zero("reset");
    reset = 1'b0;
    tick(1);

    // Legal move into column 3
    s0 = strobe_cnt;
    r0 = rej_cnt;
    issue(4'd3);
    chk("t1 strobe n+1", int'(board_column), 3);
    chk("t1 busy n+1", int'(busy), 1);
    chk("t1 count n+1", int'(move_count), 0);
    tick(1);
    chk("t1 strobe n+2", int'(board_column), 0);
    chk("t1 count n+2", int'(move_count), 1);
    tick(2);
    chk("t1 player check", int'(player), 0);
    chk("t1 busy check", int'(busy), 1);
    tick(1);
    chk("t1 player n+5", int'(player), 1);
    chk("t1 busy n+5", int'(busy), 0);
    chk("t1 strobes", strobe_cnt - s0, 1);
    chk("t1 rejects", rej_cnt - r0, 0);

    // Illegal requests: full column, col 0, cols above range
    counters[4] = 3'd6;
    s0 = strobe_cnt;
    for (int k = 0; k < 4; k++) begin
      issue(bad_cols[k]);
      chk("t2 rejected", int'(move_rejected), 1);
      chk("t2 board", int'(board_column), 0);
      chk("t2 busy", int'(busy), 0);
      tick(1);
      chk("t2 reject pulse width", int'(move_rejected), 0);
      chk("t2 player", int'(player), 1);
      chk("t2 count", int'(move_count), 1);
    end
    chk("t2 strobes", strobe_cnt - s0, 0);

    // Request during SETTLE is refused
    s0 = strobe_cnt;
    issue(4'd2);
    chk("t3 strobe", int'(board_column), 2);
    tick(1);
    move_req = 1'b1;
    move_col = 4'd4;
    tick(1);
    move_req = 1'b0;
    move_col = 4'd0;
    chk("t3 busy reject", int'(move_rejected), 1);
    chk("t3 board idle", int'(board_column), 0);
    tick(2);
    chk("t3 player", int'(player), 0);
    chk("t3 count", int'(move_count), 2);
    chk("t3 busy", int'(busy), 0);
    chk("t3 strobes", strobe_cnt - s0, 1);

    // Win by player 1
    issue(4'd1);
    tick(4);
    chk("t4 player pre", int'(player), 1);
    win_detected = 1'b1;
    issue(4'd1);
    tick(4);
    win_detected = 1'b0;
    chk("t4 game_over", int'(game_over), 1);
    chk("t4 winner", int'(winner), 1);
    chk("t4 draw", int'(draw), 0);
    chk("t4 busy", int'(busy), 1);
    chk("t4 count", int'(move_count), 4);
    chk("t4 player", int'(player), 1);
    s0 = strobe_cnt;
    r0 = rej_cnt;
    issue(4'd6);
    chk("t4 late reject", int'(move_rejected), 1);
    chk("t4 late board", int'(board_column), 0);
    tick(1);
    chk("t4 late strobes", strobe_cnt - s0, 0);
    chk("t4 late rejects", rej_cnt - r0, 1);
    chk("t4 game_over sticky", int'(game_over), 1);

    // Full board draw
    reset = 1'b1;
    tick(1);
    reset    = 1'b0;
    counters = '0;
    for (int i = 0; i < 8; i++) fill[i] = 0;
    tick(1);
    for (int k = 0; k < 47; k++) play(4'((k % 8) + 1));
    chk("t5 count 47", int'(move_count), 47);
    chk("t5 player 47", int'(player), 1);
    chk("t5 game_over 47", int'(game_over), 0);
    play(4'd8);
    chk("t5 draw", int'(draw), 1);
    chk("t5 game_over", int'(game_over), 1);
    chk("t5 count", int'(move_count), 48);
    chk("t5 player", int'(player), 1);
    chk("t5 winner", int'(winner), 0);
    chk("t5 busy", int'(busy), 1);
    issue(4'd1);
    chk("t5 post reject", int'(move_rejected), 1);
    chk("t5 post board", int'(board_column), 0);

    // Asynchronous reset during a strobe
    reset = 1'b1;
    tick(1);
    reset    = 1'b0;
    counters = '0;
    tick(1);
    issue(4'd2);
    tick(4);
    chk("t6 player pre", int'(player), 1);
    issue(4'd7);
    chk("t6 strobe", int'(board_column), 7);
    reset = 1'b1;
    #1;
    chk_idle_zero("t6 async");
    @(negedge clk);
    reset = 1'b0;
    s0 = strobe_cnt;
    tick(2);
    chk("t6 no partial strobe", strobe_cnt - s0, 0);
    chk("t6 busy after reset", int'(busy), 0);
    issue(4'd7);
    chk("t6 strobe again", int'(board_column), 7);
    tick(4);
    chk("t6 player", int'(player), 1);
    chk("t6 count", int'(move_count), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
